// File: rtl/decode_pipe_ctrl.sv
// ID stage of the pipelined MIPS core: decodes one instruction per cycle into the
// ID/EX control register with valid/ready flow control, load-use interlock and flush.
module decode_pipe_ctrl #(
   parameter int ALU_FUNC_W         = 6,
   parameter int REG_ADDR_W         = 5,
   parameter int LOAD_USE_INTERLOCK = 1,
   parameter int STALL_CNT_W        = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            instr_in,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic                   flush,
   input  logic                   ex_ready,
   output logic                   ex_valid,
   output logic [ALU_FUNC_W-1:0]  ex_alu_function,
   output logic                   ex_reg_write,
   output logic                   ex_mem_read,
   output logic                   ex_mem_write,
   output logic                   ex_uses_imm,
   output logic                   ex_imm_signed,
   output logic                   ex_is_link,
   output logic                   ex_is_jump_reg,
   output logic                   ex_is_lui,
   output logic                   ex_load_signed,
   output logic                   ex_illegal,
   output logic [1:0]             ex_mem_size,
   output logic [REG_ADDR_W-1:0]  ex_rs,
   output logic [REG_ADDR_W-1:0]  ex_rt,
   output logic [REG_ADDR_W-1:0]  ex_dest,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LB     = 6'b100000;
   localparam logic [5:0] OP_LH     = 6'b100001;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_LBU    = 6'b100100;
   localparam logic [5:0] OP_LHU    = 6'b100101;
   localparam logic [5:0] OP_SB     = 6'b101000;
   localparam logic [5:0] OP_SH     = 6'b101001;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] FN_SLL    = 6'b000000;
   localparam logic [5:0] FN_SRL    = 6'b000010;
   localparam logic [5:0] FN_SRA    = 6'b000011;
   localparam logic [5:0] FN_JR     = 6'b001000;
   localparam logic [5:0] FN_JALR   = 6'b001001;

   localparam logic [5:0] ALU_ADD   = 6'b100000;
   localparam logic [5:0] ALU_JUMP  = 6'b111010;

   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] f_rs;
   logic [4:0] f_rt;
   logic [4:0] f_rd;
   logic       unused_shamt;

   assign opcode       = instr_in[31:26];
   assign f_rs         = instr_in[25:21];
   assign f_rt         = instr_in[20:16];
   assign f_rd         = instr_in[15:11];
   assign funct        = instr_in[5:0];
   assign unused_shamt = ^instr_in[10:6];

   logic [5:0]            dec_alu;
   logic                  dec_reg_write;
   logic                  dec_mem_read;
   logic                  dec_mem_write;
   logic                  dec_uses_imm;
   logic                  dec_imm_signed;
   logic                  dec_is_link;
   logic                  dec_is_jump_reg;
   logic                  dec_is_lui;
   logic                  dec_load_signed;
   logic                  dec_illegal;
   logic [1:0]            dec_mem_size;
   logic [REG_ADDR_W-1:0] dec_dest;
   logic                  use_rs;
   logic                  use_rt;

   always_comb begin
      dec_alu         = 6'b000000;
      dec_reg_write   = 1'b0;
      dec_mem_read    = 1'b0;
      dec_mem_write   = 1'b0;
      dec_uses_imm    = 1'b0;
      dec_imm_signed  = 1'b1;
      dec_is_link     = 1'b0;
      dec_is_jump_reg = 1'b0;
      dec_is_lui      = 1'b0;
      dec_load_signed = 1'b0;
      dec_illegal     = 1'b0;
      dec_mem_size    = 2'b11;
      dec_dest        = '0;
      use_rs          = 1'b1;
      use_rt          = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            dec_alu       = funct;
            dec_dest      = REG_ADDR_W'(f_rd);
            dec_reg_write = 1'b1;
            use_rt        = 1'b1;
            case (funct)
               FN_JR: begin
                  dec_is_jump_reg = 1'b1;
                  dec_alu         = ALU_JUMP;
                  dec_reg_write   = 1'b0;
               end
               FN_JALR: begin
                  dec_is_jump_reg = 1'b1;
                  dec_is_link     = 1'b1;
                  dec_alu         = ALU_JUMP;
               end
               FN_SLL, FN_SRL, FN_SRA: use_rs = 1'b0;
               default: ;
            endcase
         end
         OP_J: begin
            dec_alu = ALU_JUMP;
            use_rs  = 1'b0;
         end
         OP_JAL: begin
            dec_alu       = ALU_JUMP;
            dec_is_link   = 1'b1;
            dec_reg_write = 1'b1;
            dec_dest      = REG_ADDR_W'(5'd31);
            use_rs        = 1'b0;
         end
         OP_BEQ: begin
            dec_alu = 6'b111100;
            use_rt  = 1'b1;
         end
         OP_BNE: begin
            dec_alu = 6'b111101;
            use_rt  = 1'b1;
         end
         OP_BLEZ: dec_alu = 6'b111110;
         OP_BGTZ: dec_alu = 6'b111111;
         OP_REGIMM: begin
            // The rt field selects the branch flavour here, it is not a register read
            if (f_rt == 5'd0) begin
               dec_alu = 6'b111000;
            end else if (f_rt == 5'd1) begin
               dec_alu = 6'b111001;
            end else begin
               dec_illegal    = 1'b1;
               dec_imm_signed = 1'b0;
            end
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            dec_uses_imm  = 1'b1;
            dec_reg_write = 1'b1;
            dec_dest      = REG_ADDR_W'(f_rt);
            case (opcode)
               OP_SLTI:  dec_alu = 6'b101010;
               OP_SLTIU: dec_alu = 6'b101011;
               OP_ANDI:  dec_alu = 6'b100100;
               OP_ORI:   dec_alu = 6'b100101;
               OP_XORI:  dec_alu = 6'b100110;
               OP_LUI:   dec_alu = 6'b100101;
               default:  dec_alu = ALU_ADD;
            endcase
            dec_imm_signed = !(opcode == OP_ANDI || opcode == OP_ORI ||
                               opcode == OP_XORI || opcode == OP_LUI);
            dec_is_lui     = (opcode == OP_LUI);
            use_rs         = (opcode != OP_LUI);
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            dec_alu         = ALU_ADD;
            dec_uses_imm    = 1'b1;
            dec_mem_read    = 1'b1;
            dec_reg_write   = 1'b1;
            dec_dest        = REG_ADDR_W'(f_rt);
            dec_load_signed = (opcode == OP_LB) || (opcode == OP_LH);
            dec_mem_size    = (opcode[1:0] == 2'b00) ? 2'b00 :
                              (opcode[1:0] == 2'b01) ? 2'b01 : 2'b11;
         end
         OP_SB, OP_SH, OP_SW: begin
            dec_alu       = ALU_ADD;
            dec_uses_imm  = 1'b1;
            dec_mem_write = 1'b1;
            use_rt        = 1'b1;
            dec_mem_size  = (opcode[1:0] == 2'b00) ? 2'b00 :
                            (opcode[1:0] == 2'b01) ? 2'b01 : 2'b11;
         end
         default: begin
            dec_illegal    = 1'b1;
            dec_imm_signed = 1'b0;
         end
      endcase
   end

   logic [REG_ADDR_W-1:0] dec_rs;
   logic [REG_ADDR_W-1:0] dec_rt;
   logic                  load_en;
   logic                  hazard;

   assign dec_rs  = REG_ADDR_W'(f_rs);
   assign dec_rt  = REG_ADDR_W'(f_rt);
   assign load_en = ex_ready || !ex_valid;

   assign hazard = (LOAD_USE_INTERLOCK != 0) && instr_valid && ex_valid && ex_mem_read &&
                   (ex_dest != '0) &&
                   ((use_rs && (dec_rs == ex_dest)) || (use_rt && (dec_rt == ex_dest)));

   // A flushed word is always consumed so IF can move on to the branch target
   assign instr_ready = rst_n && (flush || (load_en && !hazard));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid        <= 1'b0;
         ex_alu_function <= '0;
         ex_reg_write    <= 1'b0;
         ex_mem_read     <= 1'b0;
         ex_mem_write    <= 1'b0;
         ex_uses_imm     <= 1'b0;
         ex_imm_signed   <= 1'b0;
         ex_is_link      <= 1'b0;
         ex_is_jump_reg  <= 1'b0;
         ex_is_lui       <= 1'b0;
         ex_load_signed  <= 1'b0;
         ex_illegal      <= 1'b0;
         ex_mem_size     <= 2'b00;
         ex_rs           <= '0;
         ex_rt           <= '0;
         ex_dest         <= '0;
         stall_count     <= '0;
      end else if (flush) begin
         if (load_en) ex_valid <= 1'b0;
      end else if (hazard) begin
         if (load_en) begin
            ex_valid <= 1'b0;
            if (stall_count != '1) stall_count <= stall_count + STALL_CNT_W'(1);
         end
      end else if (load_en) begin
         ex_valid        <= instr_valid;
         ex_alu_function <= ALU_FUNC_W'(dec_alu);
         ex_reg_write    <= dec_reg_write;
         ex_mem_read     <= dec_mem_read;
         ex_mem_write    <= dec_mem_write;
         ex_uses_imm     <= dec_uses_imm;
         ex_imm_signed   <= dec_imm_signed;
         ex_is_link      <= dec_is_link;
         ex_is_jump_reg  <= dec_is_jump_reg;
         ex_is_lui       <= dec_is_lui;
         ex_load_signed  <= dec_load_signed;
         ex_illegal      <= dec_illegal;
         ex_mem_size     <= dec_mem_size;
         ex_rs           <= dec_rs;
         ex_rt           <= dec_rt;
         ex_dest         <= dec_dest;
      end
   end

endmodule
